sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 3, meaning clock cycles per 16-bit SRAM access phase (legal range 1..15).
REQ-002 The block SHALL have parameter MEM_BASE, default 1024, meaning the byte address that maps to SRAM halfword 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port wr_en, input, 1 bit: word-write request from the memory stage.
REQ-006 The block SHALL have port rd_en, input, 1 bit: word-read request from the memory stage.
REQ-007 The block SHALL have port address, input, 32 bits: byte address (ALU result).
REQ-008 The block SHALL have port write_data, input, 32 bits: store value.
REQ-009 The block SHALL have port read_data, output, 32 bits: last completed read word.
REQ-010 The block SHALL have port ready, output, 1 bit: low means freeze the pipeline.
REQ-011 The block SHALL have port SRAM_DQ, inout, 16 bits: SRAM data bus.
REQ-012 The block SHALL have port SRAM_ADDR, output, 18 bits: SRAM halfword address.
REQ-013 The block SHALL have port SRAM_WE_N, output, 1 bit: SRAM write enable, active-low.

Function
REQ-014 The block SHALL implement states IDLE, LOW, HIGH, DONE with a 4-bit phase counter.
REQ-015 In IDLE, a sampled request (rd_en|wr_en) SHALL move to LOW with counter cleared; no request SHALL stay in IDLE.
REQ-016 LOW and HIGH SHALL each last exactly WAIT_CYCLES cycles; LOW then HIGH, HIGH then DONE, DONE then IDLE unconditionally after one cycle.
REQ-017 ready SHALL be combinational: 1 when rd_en=0 and wr_en=0, or when state=DONE; otherwise 0.
REQ-018 The latency SHALL be: request in cycle 0 (IDLE, ready=0), LOW in cycles 1..W, HIGH in cycles W+1..2W, DONE with ready=1 in cycle 2W+1 (cycle 7 at default).
REQ-019 The address map SHALL be: word = (address - MEM_BASE) >> 2, truncated to 17 bits. SRAM_ADDR SHALL be {word,0} in LOW and {word,1} in HIGH. SRAM_ADDR is don't-care otherwise but driven {word,0}.
REQ-020 On a write, SRAM_WE_N SHALL be 0 for every LOW/HIGH cycle and 1 in IDLE and DONE. SRAM_DQ SHALL carry write_data[15:0] in LOW and write_data[31:16] in HIGH.
REQ-021 When not writing in LOW/HIGH, SRAM_DQ SHALL be high-impedance.
REQ-022 On a read, SRAM_DQ SHALL be captured on the last cycle of LOW into read_data[15:0] and on the last cycle of HIGH into read_data[31:16]. SRAM_WE_N SHALL stay 1.
REQ-023 read_data SHALL hold its value until the next read's capture; writes SHALL NOT alter it.
REQ-024 If rd_en and wr_en are both 1, the block SHALL perform the write only.
REQ-025 Request type and operands SHALL be sampled every cycle, since the frozen pipeline holds them stable. If both enables drop during LOW/HIGH, the block SHALL return to IDLE on the next edge with SRAM_WE_N=1 and read_data unchanged.
REQ-026 A request still asserted in the cycle after DONE SHALL start a new transaction from IDLE, with no extra idle cycle needed beyond that IDLE cycle.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, counter 0, read_data 0, SRAM_WE_N 1, and SRAM_DQ high-Z, including mid-transaction; the aborted write SHALL be treated as partial and unspecified in SRAM content.
REQ-028 After reset with no request, ready SHALL be 1.

Verification
REQ-029 Write test: wr_en=1, address=1024, write_data=0xDEADBEEF -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; ready 0 in cycles 0..6 and 1 in cycle 7; SRAM_WE_N low in cycles 1..6 only.
REQ-030 Read test: preload SRAM[2]=0x5678, SRAM[3]=0x1234; rd_en=1, address=1028 -> read_data=0x12345678 with ready=1 in cycle 7; SRAM_WE_N stays 1.
REQ-031 Idle and dual-request test: with no request, ready=1 and SRAM_DQ=Z. With rd_en=wr_en=1, address=1032, write_data=0xCAFEF00D -> SRAM[4]=0xF00D, SRAM[5]=0xCAFE, and read_data unchanged.
REQ-032 Reset test: assert rst in cycle 2 of a write to address 1024 -> next cycle state is IDLE, SRAM_WE_N=1, read_data=0; with the request held, ready=0 and a full 7-cycle transaction restarts.
REQ-033 Back-to-back test: a read at 1024 followed immediately by a read at 1028 -> the second ready pulse occurs 8 cycles after the first; both words are correct.
REQ-034 Parameter test: with WAIT_CYCLES=1, a write completes with ready=1 in cycle 3.

Source files
------------

// File: rtl/sram_controller_if.sv
// Memory-stage request bus of the SRAM controller.
//   wr_en / rd_en : word write / read request (held stable while ready=0)
//   address       : byte address (ALU result)
//   write_data    : store value
//   read_data     : last completed read word
//   ready         : low freezes the pipeline
// master = memory stage, slave = sram_controller.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output wr_en, rd_en, address, write_data,
                  input  read_data, ready);
  modport slave  (input  wr_en, rd_en, address, write_data,
                  output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// 32-bit word access to a 16-bit asynchronous SRAM in two phases
// (low halfword, then high halfword), each WAIT_CYCLES clocks long.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : memory-stage request bus (slave side)
//   SRAM_DQ    : bidirectional SRAM data bus
//   SRAM_ADDR  : SRAM halfword address
//   SRAM_WE_N  : SRAM write enable, active-low
module sram_controller #(
  parameter int WAIT_CYCLES = 3,
  parameter int MEM_BASE    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  bus,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [17:0]       SRAM_ADDR,
  output logic              SRAM_WE_N
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] rd_q;
  logic [31:0] offs;
  logic [16:0] word;
  logic        req, is_wr, is_rd, last, active;
  logic        unused_offs;

  // The frozen pipeline holds requests stable, so they are used live.
  // A write wins when both enables are set.
  assign req    = bus.rd_en | bus.wr_en;
  assign is_wr  = bus.wr_en;
  assign is_rd  = bus.rd_en & ~bus.wr_en;
  assign last   = (cnt == 4'(WAIT_CYCLES - 1));
  assign active = (state == LOW) || (state == HIGH);

  assign offs        = bus.address - 32'(MEM_BASE);
  assign word        = offs[18:2];
  assign unused_offs = ^{offs[31:19], offs[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (req) begin
        state_nx = LOW;
        cnt_nx   = '0;
      end
      LOW, HIGH: begin
        if (!req) begin
          // Request withdrawn mid-access: abandon it.
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (last) begin
          state_nx = (state == LOW) ? HIGH : DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt + 4'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Each halfword is captured on the final cycle of its phase, when the
  // SRAM has had the full wait time to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (is_rd && last) begin
      if (state == LOW)  rd_q[15:0]  <= SRAM_DQ;
      if (state == HIGH) rd_q[31:16] <= SRAM_DQ;
    end
  end

  assign bus.read_data = rd_q;
  assign bus.ready     = !req || (state == DONE);
  assign SRAM_ADDR     = {word, state == HIGH};
  assign SRAM_WE_N     = !(is_wr && active);
  assign SRAM_DQ       = (is_wr && active)
                         ? ((state == HIGH) ? bus.write_data[31:16] : bus.write_data[15:0])
                         : 16'hzzzz;
endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_controller_if bif ();
  sram_controller_if bif1 ();

  tri1  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  tri1  [15:0] dq1;
  logic [17:0] addr1;
  logic        we_n1;

  sram_controller dut (
    .clk(clk), .rst(rst), .bus(bif.slave),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n)
  );

  sram_controller #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bif1.slave),
    .SRAM_DQ(dq1), .SRAM_ADDR(addr1), .SRAM_WE_N(we_n1)
  );

  // SRAM model: drives the bus on reads only when the bench enables it.
  logic [15:0] mem [0:63];
  logic        sram_oe;
  assign sram_dq = (sram_oe && sram_we_n) ? mem[sram_addr[5:0]] : 16'hzzzz;
  always @(posedge clk) if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic test_reset();
    n_cmp++; if (bif.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", bif.ready); end
    n_cmp++; if (bif.read_data !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h exp 0", bif.read_data); end
    n_cmp++; if (sram_we_n !== 1'b1) begin n_bad++; $display("FAIL reset_we_n got %b exp 1", sram_we_n); end
  endtask

  task automatic test_idle();
    bif.write_data = 32'h1234_0000;
    @(negedge clk); #1;
    n_cmp++; if (bif.ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready got %b exp 1", bif.ready); end
    n_cmp++; if (sram_dq !== 16'hFFFF) begin n_bad++; $display("FAIL idle_dq_z got %h exp pulled FFFF", sram_dq); end
  endtask

  task automatic test_write();
    @(negedge clk);
    bif.wr_en = 1'b1; bif.address = 32'd1024; bif.write_data = 32'hDEADBEEF; #1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_cmp++; if (bif.ready !== (c == 7)) begin n_bad++; $display("FAIL wr_ready c%0d got %b exp %b", c, bif.ready, c == 7); end
      n_cmp++; if (sram_we_n !== !(c >= 1 && c <= 6)) begin n_bad++; $display("FAIL wr_we_n c%0d got %b", c, sram_we_n); end
      if (c == 1) begin n_cmp++; if (sram_dq !== 16'hBEEF) begin n_bad++; $display("FAIL wr_dq_lo got %h exp BEEF", sram_dq); end end
      if (c == 4) begin n_cmp++; if (sram_dq !== 16'hDEAD) begin n_bad++; $display("FAIL wr_dq_hi got %h exp DEAD", sram_dq); end end
      if (c == 4) begin n_cmp++; if (sram_addr !== 18'd1) begin n_bad++; $display("FAIL wr_addr_hi got %0d exp 1", sram_addr); end end
    end
    bif.wr_en = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (mem[0] !== 16'hBEEF) begin n_bad++; $display("FAIL wr_mem0 got %h exp BEEF", mem[0]); end
    n_cmp++; if (mem[1] !== 16'hDEAD) begin n_bad++; $display("FAIL wr_mem1 got %h exp DEAD", mem[1]); end
  endtask

  task automatic test_read();
    mem[2] = 16'h5678; mem[3] = 16'h1234;
    @(negedge clk);
    sram_oe = 1'b1; bif.rd_en = 1'b1; bif.address = 32'd1028; #1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_cmp++; if (bif.ready !== (c == 7)) begin n_bad++; $display("FAIL rd_ready c%0d got %b exp %b", c, bif.ready, c == 7); end
      n_cmp++; if (sram_we_n !== 1'b1) begin n_bad++; $display("FAIL rd_we_n c%0d got %b exp 1", c, sram_we_n); end
    end
    n_cmp++; if (bif.read_data !== 32'h12345678) begin n_bad++; $display("FAIL rd_data got %h exp 12345678", bif.read_data); end
    bif.rd_en = 1'b0; sram_oe = 1'b0;
  endtask

  task automatic test_dual();
    @(negedge clk);
    bif.rd_en = 1'b1; bif.wr_en = 1'b1; bif.address = 32'd1032; bif.write_data = 32'hCAFEF00D; #1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_cmp++; if (bif.ready !== (c == 7)) begin n_bad++; $display("FAIL dual_ready c%0d got %b exp %b", c, bif.ready, c == 7); end
    end
    bif.rd_en = 1'b0; bif.wr_en = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (mem[4] !== 16'hF00D) begin n_bad++; $display("FAIL dual_mem4 got %h exp F00D", mem[4]); end
    n_cmp++; if (mem[5] !== 16'hCAFE) begin n_bad++; $display("FAIL dual_mem5 got %h exp CAFE", mem[5]); end
    n_cmp++; if (bif.read_data !== 32'h12345678) begin n_bad++; $display("FAIL dual_rdata got %h exp 12345678", bif.read_data); end
  endtask

  // Read withdrawn during LOW, then a fresh read must take the full 7 cycles.
  task automatic test_abort();
    @(negedge clk);
    sram_oe = 1'b1; bif.rd_en = 1'b1; bif.address = 32'd1028; #1;
    @(negedge clk); #1;
    @(negedge clk); bif.rd_en = 1'b0; #1;
    n_cmp++; if (bif.ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready got %b exp 1", bif.ready); end
    @(negedge clk); #1;
    n_cmp++; if (bif.read_data !== 32'h12345678) begin n_bad++; $display("FAIL abort_rdata got %h exp 12345678", bif.read_data); end
    bif.rd_en = 1'b1; bif.address = 32'd1024; #1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_cmp++; if (bif.ready !== (c == 7)) begin n_bad++; $display("FAIL abort_rerun_ready c%0d got %b exp %b", c, bif.ready, c == 7); end
    end
    n_cmp++; if (bif.read_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL abort_rerun_data got %h exp DEADBEEF", bif.read_data); end
    bif.rd_en = 1'b0; sram_oe = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    sram_oe = 1'b1; bif.rd_en = 1'b1; bif.address = 32'd1024; #1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_cmp++; if (bif.ready !== (c == 7 || c == 15)) begin n_bad++; $display("FAIL b2b_ready c%0d got %b", c, bif.ready); end
      if (c == 7) begin
        n_cmp++; if (bif.read_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b_first got %h exp DEADBEEF", bif.read_data); end
        bif.address = 32'd1028;
      end
    end
    n_cmp++; if (bif.read_data !== 32'h12345678) begin n_bad++; $display("FAIL b2b_second got %h exp 12345678", bif.read_data); end
    bif.rd_en = 1'b0; sram_oe = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bif.wr_en = 1'b1; bif.address = 32'd1024; bif.write_data = 32'h1111_2222; #1;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (c == 3) begin
        rst = 1'b0;
        n_cmp++; if (sram_we_n !== 1'b1) begin n_bad++; $display("FAIL rstmid_we_n got %b exp 1", sram_we_n); end
        n_cmp++; if (bif.read_data !== 32'h0) begin n_bad++; $display("FAIL rstmid_rdata got %h exp 0", bif.read_data); end
      end
      if (c >= 3) begin
        n_cmp++; if (bif.ready !== (c == 10)) begin n_bad++; $display("FAIL rstmid_ready c%0d got %b exp %b", c, bif.ready, c == 10); end
        n_cmp++; if (sram_we_n !== !(c >= 4 && c <= 9)) begin n_bad++; $display("FAIL rstmid_we c%0d got %b", c, sram_we_n); end
      end
      if (c == 2) rst = 1'b1;
    end
    bif.wr_en = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (mem[1] !== 16'h1111) begin n_bad++; $display("FAIL rstmid_mem1 got %h exp 1111", mem[1]); end
  endtask

  task automatic test_param();
    @(negedge clk);
    bif1.wr_en = 1'b1; bif1.address = 32'd1024; bif1.write_data = 32'hA5A5_5A5A; #1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_cmp++; if (bif1.ready !== (c == 3)) begin n_bad++; $display("FAIL param_ready c%0d got %b exp %b", c, bif1.ready, c == 3); end
      n_cmp++; if (we_n1 !== !(c == 1 || c == 2)) begin n_bad++; $display("FAIL param_we c%0d got %b", c, we_n1); end
    end
    bif1.wr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    rst = 1'b1; sram_oe = 1'b0;
    bif.wr_en = 1'b0; bif.rd_en = 1'b0; bif.address = '0; bif.write_data = '0;
    bif1.wr_en = 1'b0; bif1.rd_en = 1'b0; bif1.address = '0; bif1.write_data = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    test_reset();
    test_idle();
    test_write();
    test_read();
    test_dual();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
